// File: rtl/ahb_lite_pkg.sv
// AHB-Lite bus encodings and the burst master FSM state type.
// Shared by ahb_burst_addr_gen and ahb_lite_burst_master.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HS_BYTE  = 3'd0,
        HS_HALF  = 3'd1,
        HS_WORD  = 3'd2,
        HS_DWORD = 3'd3
    } hsize_e;

    typedef enum logic {
        HR_OKAY  = 1'b0,
        HR_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NSEQ = 2'd1,
        ST_SEQ  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic f_is_wrap(input logic [2:0] burst);
        return (burst == HB_WRAP4) || (burst == HB_WRAP8) ||
               (burst == HB_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Combinational burst helper: beat count, wrap mask and next beat address.
// Ports: i_addr/i_size/i_burst/i_len in; o_next_addr, o_beats out.
module ahb_burst_addr_gen
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5,
    parameter int CNT_W  = 6
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [2:0]        i_burst,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic [CNT_W-1:0]  o_beats
);

    logic [CNT_W-1:0]  w_beats;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;

    always_comb begin
        w_beats = CNT_W'(1);
        case (i_burst)
            HB_SINGLE:            w_beats = CNT_W'(1);
            HB_INCR:              w_beats = CNT_W'(i_len) + CNT_W'(1);
            HB_WRAP4,  HB_INCR4:  w_beats = CNT_W'(4);
            HB_WRAP8,  HB_INCR8:  w_beats = CNT_W'(8);
            HB_WRAP16, HB_INCR16: w_beats = CNT_W'(16);
            default:              w_beats = CNT_W'(1);
        endcase
    end

    assign w_step = ADDR_W'(1) << i_size;
    assign w_inc  = i_addr + w_step;
    // Wrap boundary spans the whole burst: beats * bytes-per-beat.
    assign w_mask = (ADDR_W'(w_beats) << i_size) - ADDR_W'(1);

    assign o_beats     = w_beats;
    assign o_next_addr = f_is_wrap(i_burst) ?
                         ((i_addr & ~w_mask) | (w_inc & w_mask)) : w_inc;

endmodule

// File: rtl/ahb_lite_burst_master.sv
// Command-driven AHB-Lite burst master (SINGLE/INCR/INCRn/WRAPn).
// Cmd port: cmd_*, wdata/wdata_req, rdata/rdata_valid, resp_err, done.
// Bus port: H* signals. Define AHB_ERR_ABORT_EN to abort a burst on ERROR.
module ahb_lite_burst_master
    import ahb_lite_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter int         LEN_W     = 5,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [2:0]        cmd_burst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              resp_err,
    output logic              done,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [1:0]        HTRANS,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    localparam int CNT_W = (LEN_W >= 4) ? LEN_W + 1 : 5;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dp_valid;
    logic              r_dp_write;
    logic              r_dp_last;
    logic              r_cmd_ready;
    logic              r_rdata_valid;
    logic              r_resp_err;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_hwdata;
    logic [ADDR_W-1:0] r_haddr;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [2:0]        r_hburst;
    logic [1:0]        r_htrans;

    logic              w_idle;
    logic              w_addr_acc;
    logic              w_dp_done;
    logic [ADDR_W-1:0] w_gen_addr;
    logic [2:0]        w_gen_size;
    logic [2:0]        w_gen_burst;
    logic [ADDR_W-1:0] w_next_addr;
    logic [CNT_W-1:0]  w_beats;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_addr_acc = ((r_state == ST_NSEQ) || (r_state == ST_SEQ)) && HREADY;
    assign w_dp_done  = r_dp_valid && HREADY;

    // In IDLE the generator sizes the incoming command; otherwise it
    // steps the address of the burst in flight.
    assign w_gen_addr  = w_idle ? cmd_addr  : r_haddr;
    assign w_gen_size  = w_idle ? cmd_size  : r_hsize;
    assign w_gen_burst = w_idle ? cmd_burst : r_hburst;

    ahb_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .i_addr      (w_gen_addr),
        .i_size      (w_gen_size),
        .i_burst     (w_gen_burst),
        .i_len       (cmd_len),
        .o_next_addr (w_next_addr),
        .o_beats     (w_beats)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_dp_valid    <= 1'b0;
            r_dp_write    <= 1'b0;
            r_dp_last     <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rdata_valid <= 1'b0;
            r_resp_err    <= 1'b0;
            r_done        <= 1'b0;
            r_rdata       <= '0;
            r_hwdata      <= '0;
            r_haddr       <= '0;
            r_hwrite      <= 1'b0;
            r_hsize       <= HS_BYTE;
            r_hburst      <= HB_SINGLE;
            r_htrans      <= HT_IDLE;
        end else begin
            r_rdata_valid <= 1'b0;
            r_resp_err    <= 1'b0;
            r_done        <= 1'b0;

            if (w_dp_done) begin
                if (HRESP == HR_ERROR) begin
                    r_resp_err <= 1'b1;
                end else if (!r_dp_write) begin
                    r_rdata       <= HRDATA;
                    r_rdata_valid <= 1'b1;
                end
                if (r_dp_last) r_done <= 1'b1;
            end

            if (HREADY) r_dp_valid <= w_addr_acc;

            if (w_addr_acc) begin
                r_dp_write <= r_hwrite;
                r_dp_last  <= (r_cnt == CNT_W'(1));
                if (r_hwrite) r_hwdata <= wdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_haddr     <= cmd_addr;
                        r_hwrite    <= cmd_write;
                        r_hsize     <= cmd_size;
                        r_hburst    <= cmd_burst;
                        r_htrans    <= HT_NONSEQ;
                        r_cnt       <= w_beats;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_NSEQ;
                    end
                end
                ST_NSEQ, ST_SEQ: begin
                    if (HREADY) begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_htrans    <= HT_IDLE;
                            r_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_haddr  <= w_next_addr;
                            r_htrans <= HT_SEQ;
                            r_cnt    <= r_cnt - CNT_W'(1);
                            r_state  <= ST_SEQ;
                        end
                    end
`ifdef AHB_ERR_ABORT_EN
                    // Only abort when the errored beat has siblings still
                    // to issue; a last-beat error needs no cancellation.
                    else if (r_dp_valid && !r_dp_last &&
                             (HRESP == HR_ERROR)) begin
                        r_htrans  <= HT_IDLE;
                        r_dp_last <= 1'b1;
                        r_state   <= ST_ERR;
                    end
`endif
                end
                ST_ERR: begin
                    if (HREADY) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign wdata_req   = w_addr_acc && r_hwrite;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign resp_err    = r_resp_err;
    assign done        = r_done;
    assign HADDR       = r_haddr;
    assign HWRITE      = r_hwrite;
    assign HSIZE       = r_hsize;
    assign HBURST      = r_hburst;
    assign HPROT       = HPROT_VAL;
    assign HTRANS      = r_htrans;
    assign HMASTLOCK   = 1'b0;
    assign HWDATA      = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Directed self-checking bench for ahb_lite_burst_master.
// Honours AHB_ERR_ABORT_EN for the error-response expectations.
module tb_ahb_lite_burst_master;
    import ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_size = '0;
    logic [2:0]  cmd_burst = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] wdata = '0;
    logic        wdata_req;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        resp_err;
    logic        done;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [31:0] HRDATA = '0;

    int checks = 0;
    int errors = 0;
    int n_wreq = 0;
    int n_err = 0;
    int w0;
    int e0;

    logic [31:0] incr4_addr [4] = '{32'h20, 32'h24, 32'h28, 32'h2C};
    logic [31:0] wrap8_addr [8] = '{32'h34, 32'h38, 32'h3C, 32'h20,
                                    32'h24, 32'h28, 32'h2C, 32'h30};

    ahb_lite_burst_master #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .LEN_W     (5),
        .HPROT_VAL (4'b0011)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_size    (cmd_size),
        .cmd_burst   (cmd_burst),
        .cmd_len     (cmd_len),
        .wdata       (wdata),
        .wdata_req   (wdata_req),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .resp_err    (resp_err),
        .done        (done),
        .HADDR       (HADDR),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HTRANS      (HTRANS),
        .HMASTLOCK   (HMASTLOCK),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (wdata_req) n_wreq++;
        if (resp_err) n_err++;
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [2:0] b,
                       input logic [4:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_burst = b;
        cmd_len   = l;
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_htrans", HTRANS, HT_IDLE);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hsize", HSIZE, 3'd0);
        chk("rst_hburst", HBURST, HB_SINGLE);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_hprot", HPROT, 4'b0011);
        chk("rst_hmastlock", HMASTLOCK, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_pulses", {rdata_valid, resp_err, done, wdata_req}, 4'b0);
        HRESETn = 1'b1;
        tick;

        // Single write, zero waits
        cmd(1'b1, 32'h100, HS_WORD, HB_SINGLE, 5'd0);
        wdata = 32'hDEADBEEF;
        chk("sw_ready", cmd_ready, 1'b1);
        tick;
        cmd_valid = 1'b0;
        chk("sw_trans", HTRANS, HT_NONSEQ);
        chk("sw_addr", HADDR, 32'h100);
        chk("sw_hwrite", HWRITE, 1'b1);
        chk("sw_hsize", HSIZE, HS_WORD);
        chk("sw_busy", cmd_ready, 1'b0);
        #1;
        chk("sw_wreq", wdata_req, 1'b1);
        tick;
        chk("sw_hwdata", HWDATA, 32'hDEADBEEF);
        chk("sw_idle", HTRANS, HT_IDLE);
        chk("sw_done_early", done, 1'b0);
        tick;
        chk("sw_done", done, 1'b1);
        tick;
        chk("sw_done_pulse", done, 1'b0);

        // INCR4 read, data 1..4
        cmd(1'b0, 32'h20, HS_WORD, HB_INCR4, 5'd0);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                chk("i4_trans", HTRANS, (i == 0) ? HT_NONSEQ : HT_SEQ);
                chk("i4_addr", HADDR, incr4_addr[i]);
            end else begin
                chk("i4_end", HTRANS, HT_IDLE);
            end
            if (i > 1) begin
                chk("i4_rvalid", rdata_valid, 1'b1);
                chk("i4_rdata", rdata, 32'(i - 1));
            end
            if (i > 0) HRDATA = 32'(i);
            tick;
        end
        chk("i4_rvalid_last", rdata_valid, 1'b1);
        chk("i4_rdata_last", rdata, 32'd4);
        chk("i4_done", done, 1'b1);
        tick;
        chk("i4_rvalid_off", rdata_valid, 1'b0);

        // WRAP8 read at 0x34
        cmd(1'b0, 32'h34, HS_WORD, HB_WRAP8, 5'd0);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("w8_addr", HADDR, wrap8_addr[i]);
            HRDATA = 32'h100 + 32'(i);
            tick;
        end
        chk("w8_end", HTRANS, HT_IDLE);
        tick;
        chk("w8_done", done, 1'b1);
        chk("w8_rdata", rdata, 32'h107);
        tick;

        // INCR len=2 write, two wait states on beat 1
        cmd(1'b1, 32'h200, HS_WORD, HB_INCR, 5'd2);
        wdata = 32'hA0;
        w0 = n_wreq;
        tick;
        cmd_valid = 1'b0;
        chk("iw_addr0", HADDR, 32'h200);
        tick;
        wdata = 32'hA1;
        chk("iw_addr1", HADDR, 32'h204);
        chk("iw_wd0", HWDATA, 32'hA0);
        tick;
        wdata = 32'hA2;
        HREADY = 1'b0;
        chk("iw_addr2", HADDR, 32'h208);
        chk("iw_wd1", HWDATA, 32'hA1);
        #1;
        chk("iw_wreq_wait", wdata_req, 1'b0);
        tick;
        chk("iw_hold_addr", HADDR, 32'h208);
        chk("iw_hold_wd", HWDATA, 32'hA1);
        chk("iw_hold_trans", HTRANS, HT_SEQ);
        tick;
        HREADY = 1'b1;
        chk("iw_hold_addr2", HADDR, 32'h208);
        chk("iw_hold_wd2", HWDATA, 32'hA1);
        tick;
        wdata = 32'hA3;
        chk("iw_wd2", HWDATA, 32'hA2);
        chk("iw_idle", HTRANS, HT_IDLE);
        tick;
        chk("iw_done", done, 1'b1);
        chk("iw_wreq_cnt", n_wreq - w0, 3);

        // INCR4 write with ERROR on beat 2
        cmd(1'b1, 32'h300, HS_WORD, HB_INCR4, 5'd0);
        w0 = n_wreq;
        e0 = n_err;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        tick;
        HREADY = 1'b0;
        HRESP = 1'b1;
        chk("er_trans1", HTRANS, HT_SEQ);
        chk("er_addr3", HADDR, 32'h30C);
        tick;
        HREADY = 1'b1;
`ifdef AHB_ERR_ABORT_EN
        chk("er_abort_idle", HTRANS, HT_IDLE);
        chk("er_no_accept", cmd_ready, 1'b0);
`else
        chk("er_cont_trans", HTRANS, HT_SEQ);
        chk("er_cont_addr", HADDR, 32'h30C);
`endif
        tick;
        HRESP = 1'b0;
        chk("er_resp_err", resp_err, 1'b1);
        chk("er_idle", HTRANS, HT_IDLE);
`ifdef AHB_ERR_ABORT_EN
        chk("er_abort_done", done, 1'b1);
        chk("er_abort_ready", cmd_ready, 1'b1);
`else
        chk("er_cont_done_early", done, 1'b0);
`endif
        tick;
`ifdef AHB_ERR_ABORT_EN
        chk("er_wreq_cnt", n_wreq - w0, 3);
`else
        chk("er_cont_done", done, 1'b1);
        chk("er_wreq_cnt", n_wreq - w0, 4);
`endif
        chk("er_err_cnt", n_err - e0, 1);

        // Reset in the middle of an INCR8 read
        cmd(1'b0, 32'h400, HS_WORD, HB_INCR8, 5'd0);
        tick;
        cmd_valid = 1'b0;
        tick;
        HRDATA = 32'h77;
        tick;
        chk("rm_mid_addr", HADDR, 32'h408);
        chk("rm_mid_rdata", rdata, 32'h77);
        HRESETn = 1'b0;
        #1;
        chk("rm_htrans", HTRANS, HT_IDLE);
        chk("rm_haddr", HADDR, 32'h0);
        chk("rm_hburst", HBURST, HB_SINGLE);
        chk("rm_hwdata", HWDATA, 32'h0);
        chk("rm_rdata", rdata, 32'h0);
        chk("rm_rvalid", rdata_valid, 1'b0);
        chk("rm_ready", cmd_ready, 1'b1);
        tick;
        tick;
        HRESETn = 1'b1;
        tick;

        // Single read after reset release
        cmd(1'b0, 32'h500, HS_WORD, HB_SINGLE, 5'd0);
        tick;
        cmd_valid = 1'b0;
        chk("sr_trans", HTRANS, HT_NONSEQ);
        chk("sr_addr", HADDR, 32'h500);
        chk("sr_rvalid_none", rdata_valid, 1'b0);
        tick;
        HRDATA = 32'h55;
        chk("sr_rvalid_early", rdata_valid, 1'b0);
        tick;
        chk("sr_rvalid", rdata_valid, 1'b1);
        chk("sr_rdata", rdata, 32'h55);
        chk("sr_done", done, 1'b1);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
